fetch_unit: RTL and testbench

Instruction-fetch stage of the 5-stage pipeline. It sits directly upstream of the IF/ID instruction register.
- Owns the PC and selects the next PC from the ID-stage pcsource controls.
- Runs a single-outstanding request/ready handshake to instruction memory.
- Presents if_pc4/if_inst to the IF/ID register, substituting NOP bubbles while memory is waiting.
- Remembers a branch redirect that arrives while its delay-slot fetch is still pending.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/fetch_unit_npc_mux.sv | 33 +++
 rtl/fetch_unit.sv | 142 ++++++++++++++
 tb/tb_fetch_unit.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the pipeline front end.
//   - pcsource encodings driven by the ID stage
//   - fetch state encoding
//   - default bubble word
//   - pc+4 helper shared by the fetch datapath and its models
package cpu_pkg;

    localparam logic [1:0] PCS_PC4 = 2'b00;
    localparam logic [1:0] PCS_BR  = 2'b01;
    localparam logic [1:0] PCS_JR  = 2'b10;
    localparam logic [1:0] PCS_J   = 2'b11;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic {
        S_BUSY = 1'b0,  // request outstanding to instruction memory
        S_HAVE = 1'b1   // fetched word parked in buf, no request
    } state_t;

    // Sequential successor address; wraps silently at 2^32.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_unit_npc_mux.sv
// Next-PC selection for the fetch stage.
// Ports:
//   pc        in  current fetch PC
//   pcsource  in  ID-stage select (pc+4 / branch / jr / jump)
//   bpc, rpc, jpc in candidate targets
//   pc4       out pc+4 (wrapping)
//   npc       out selected next PC
module npc_mux
    import cpu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    output logic [31:0] pc4,
    output logic [31:0] npc
);

    // 4:1 next-PC select plus sequential adder.
    always_comb begin
        pc4 = pc_plus4(pc);
        npc = pc4;
        case (pcsource)
            PCS_PC4: npc = pc4;
            PCS_BR:  npc = bpc;
            PCS_JR:  npc = rpc;
            PCS_J:   npc = jpc;
            default: npc = pc4;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage feeding the IF/ID register.
// Owns the PC, runs a single-outstanding req/ready handshake to instruction
// memory, presents bubbles while memory waits, and remembers a control
// transfer that leaves ID while its delay-slot fetch is still outstanding.
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   wpcir             PC/IR write enable (0 = ID stall)
//   pcsource, bpc, rpc, jpc   next-PC controls and targets from ID
//   imem_req/addr     request to instruction memory (addr = pc)
//   imem_ready/rdata  response; rdata valid while ready=1
//   if_pc4/inst/valid presented instruction for IF/ID
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = NOP_WORD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wpcir,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_pc4,
    output logic [31:0] if_inst,
    output logic        if_valid
);

    state_t      state_q,      state_d;
    logic [31:0] pc_q,         pc_d;
    logic [31:0] buf_q,        buf_d;
    logic        redir_pend_q, redir_pend_d;
    logic [31:0] redir_pc_q,   redir_pc_d;

    logic [31:0] pc4_s;
    logic [31:0] mux_npc_s;
    logic [31:0] npc_s;
    logic        valid_s;
    logic        cons_s;

    npc_mux u_npc_mux (
        .pc       (pc_q),
        .pcsource (pcsource),
        .bpc      (bpc),
        .rpc      (rpc),
        .jpc      (jpc),
        .pc4      (pc4_s),
        .npc      (mux_npc_s)
    );

    // Presentation to IF/ID; a word straight off the memory bus bypasses buf.
    always_comb begin
        valid_s  = 1'b0;
        imem_req = 1'b0;
        if_inst  = NOP_INST;
        if_pc4   = RESET_PC + 32'd4;
        if (rst) begin
            valid_s  = 1'b0;
            imem_req = 1'b0;
            if_inst  = NOP_INST;
            if_pc4   = RESET_PC + 32'd4;
        end else begin
            imem_req = (state_q == S_BUSY);
            if_pc4   = pc4_s;
            if (state_q == S_HAVE) begin
                valid_s = 1'b1;
                if_inst = buf_q;
            end else if (imem_ready) begin
                valid_s = 1'b1;
                if_inst = imem_rdata;
            end else begin
                valid_s = 1'b0;
                if_inst = NOP_INST;
            end
        end
        imem_addr = pc_q;
        if_valid  = valid_s;
        cons_s    = wpcir & valid_s;
        // A remembered redirect overrides whatever ID shows (ID holds a bubble).
        npc_s     = redir_pend_q ? redir_pc_q : mux_npc_s;
    end

    // Next-state: handshake FSM, PC update and redirect capture/use.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        buf_d        = buf_q;
        redir_pend_d = redir_pend_q;
        redir_pc_d   = redir_pc_q;
        if (cons_s) begin
            pc_d         = npc_s;
            state_d      = S_BUSY;
            redir_pend_d = 1'b0;
        end else begin
            case (state_q)
                S_BUSY: begin
                    if (imem_ready) begin
                        // Here wpcir=0: park the word until ID can take it.
                        buf_d   = imem_rdata;
                        state_d = S_HAVE;
                    end else if (wpcir && !redir_pend_q && (pcsource != PCS_PC4)) begin
                        // Control transfer left ID while its delay slot is
                        // still being fetched: keep the target for later.
                        redir_pc_d   = mux_npc_s;
                        redir_pend_d = 1'b1;
                    end else begin
                        state_d = S_BUSY;
                    end
                end
                S_HAVE: begin
                    state_d = S_HAVE;
                end
                default: begin
                    state_d = S_BUSY;
                end
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_BUSY;
            pc_q         <= RESET_PC;
            buf_q        <= NOP_INST;
            redir_pend_q <= 1'b0;
            redir_pc_q   <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            buf_q        <= buf_d;
            redir_pend_q <= redir_pend_d;
            redir_pc_q   <= redir_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit. Memory returns
// 32'hE000_0000 ^ address so every expected word is known in advance.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        wpcir;
    logic [1:0]  pcsource;
    logic [31:0] bpc, rpc, jpc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] if_pc4;
    logic [31:0] if_inst;
    logic        if_valid;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign imem_rdata = 32'hE000_0000 ^ imem_addr;

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .NOP_INST (32'h0000_0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wpcir      (wpcir),
        .pcsource   (pcsource),
        .bpc        (bpc),
        .rpc        (rpc),
        .jpc        (jpc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .if_pc4     (if_pc4),
        .if_inst    (if_inst),
        .if_valid   (if_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Check the full presented view of one cycle.
    task automatic view(input string tag, input logic req, input logic [31:0] addr,
                        input logic vld, input logic [31:0] inst, input logic [31:0] pc4);
        #1;
        chk({tag, ".req"},   {31'd0, imem_req}, {31'd0, req});
        chk({tag, ".addr"},  imem_addr, addr);
        chk({tag, ".valid"}, {31'd0, if_valid}, {31'd0, vld});
        chk({tag, ".inst"},  if_inst, inst);
        chk({tag, ".pc4"},   if_pc4, pc4);
    endtask

    initial begin
        rst = 1'b1; wpcir = 1'b1; pcsource = 2'b00;
        bpc = 32'h0; rpc = 32'h0; jpc = 32'h0; imem_ready = 1'b1;
        cyc();
        // Reset view
        view("rst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h4);

        // Zero-wait streaming 0,4,8,C
        rst = 1'b0;
        view("zw0", 1'b1, 32'h0, 1'b1, 32'hE000_0000, 32'h4);  cyc();
        view("zw1", 1'b1, 32'h4, 1'b1, 32'hE000_0004, 32'h8);  cyc();
        view("zw2", 1'b1, 32'h8, 1'b1, 32'hE000_0008, 32'hC);  cyc();
        view("zw3", 1'b1, 32'hC, 1'b1, 32'hE000_000C, 32'h10); cyc();

        // Two wait states at 0x10
        imem_ready = 1'b0;
        view("w0", 1'b1, 32'h10, 1'b0, 32'h0, 32'h14); cyc();
        view("w1", 1'b1, 32'h10, 1'b0, 32'h0, 32'h14); cyc();
        imem_ready = 1'b1;
        view("w2", 1'b1, 32'h10, 1'b1, 32'hE000_0010, 32'h14); cyc();
        view("w3", 1'b1, 32'h14, 1'b1, 32'hE000_0014, 32'h18);

        // Stall: word at 0x14 parked in buf, held for 3 cycles
        wpcir = 1'b0; cyc();
        imem_ready = 1'b0;
        view("st0", 1'b0, 32'h14, 1'b1, 32'hE000_0014, 32'h18); cyc();
        view("st1", 1'b0, 32'h14, 1'b1, 32'hE000_0014, 32'h18); cyc();
        view("st2", 1'b0, 32'h14, 1'b1, 32'hE000_0014, 32'h18);
        wpcir = 1'b1;
        view("st3", 1'b0, 32'h14, 1'b1, 32'hE000_0014, 32'h18); cyc();
        imem_ready = 1'b1;
        view("st4", 1'b1, 32'h18, 1'b1, 32'hE000_0018, 32'h1C);

        // Branch with delay slot ready: 0x18 consumed, go to 0x100
        pcsource = 2'b01; bpc = 32'h100; cyc();
        pcsource = 2'b10; rpc = 32'h300;
        view("br", 1'b1, 32'h100, 1'b1, 32'hE000_0100, 32'h104); cyc();
        pcsource = 2'b00;
        view("jr", 1'b1, 32'h300, 1'b1, 32'hE000_0300, 32'h304);

        // Pending redirect: 0x300 waiting, jump to 0x200 leaves ID
        imem_ready = 1'b0; pcsource = 2'b11; jpc = 32'h200;
        view("pr0", 1'b1, 32'h300, 1'b0, 32'h0, 32'h304); cyc();
        pcsource = 2'b01; bpc = 32'h999;  // must be ignored while pending
        view("pr1", 1'b1, 32'h300, 1'b0, 32'h0, 32'h304);
        chk("pr1.pend", {31'd0, dut.redir_pend_q}, 32'h1); cyc();
        imem_ready = 1'b1;
        view("pr2", 1'b1, 32'h300, 1'b1, 32'hE000_0300, 32'h304); cyc();
        pcsource = 2'b00;
        view("pr3", 1'b1, 32'h200, 1'b1, 32'hE000_0200, 32'h204);
        chk("pr3.pend", {31'd0, dut.redir_pend_q}, 32'h0);

        // Wrap boundary: jr to 0xFFFFFFFC, pc+4 wraps to 0
        pcsource = 2'b10; rpc = 32'hFFFF_FFFC; cyc();
        pcsource = 2'b11; jpc = 32'h40;
        view("wrap", 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h1FFF_FFFC, 32'h0); cyc();

        // Reset mid-wait at 0x40 with a redirect pending
        imem_ready = 1'b0; pcsource = 2'b11; jpc = 32'h500;
        view("rw0", 1'b1, 32'h40, 1'b0, 32'h0, 32'h44); cyc();
        pcsource = 2'b00;
        chk("rw1.pend", {31'd0, dut.redir_pend_q}, 32'h1);
        rst = 1'b1;
        #1;
        chk("rw1.req",   {31'd0, imem_req}, 32'h0);
        chk("rw1.valid", {31'd0, if_valid}, 32'h0);
        chk("rw1.pc4",   if_pc4, 32'h4);
        cyc();
        rst = 1'b0;
        view("rw2", 1'b1, 32'h0, 1'b0, 32'h0, 32'h4);
        chk("rw2.pend", {31'd0, dut.redir_pend_q}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
